// File: rtl/adat_frame_writer_if.sv
// Sample handshake between the ADAT decoder (master) and adat_frame_writer (slave).
// The user-bit lane exists only when ADAT_FRAME_WRITER_USER_BITS_EN is defined.
interface adat_frame_writer_if;
    logic        sample_valid_i;
    logic [2:0]  sample_chan_i;
    logic [23:0] sample_i;
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
    logic [3:0]  user_bits_i;
`endif
    logic        sample_ready_o;

    modport master (
        input  sample_ready_o,
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
        output user_bits_i,
`endif
        output sample_valid_i, sample_chan_i, sample_i
    );

    modport slave (
        output sample_ready_o,
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
        input  user_bits_i,
`endif
        input  sample_valid_i, sample_chan_i, sample_i
    );
endinterface

// File: rtl/adat_frame_writer.sv
// Serialises 8 ADAT channel samples per frame into a 1-bit circular frame RAM and
// raises resync once the stream is trusted. Optional macro: ADAT_FRAME_WRITER_USER_BITS_EN.
module adat_frame_writer #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int LOCK_FRAMES   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       adat_locked_i,
    adat_frame_writer_if.slave         bus,
    output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
    output logic                       ram_write_data_o,
    output logic                       ram_write_en_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
    output logic                       resync_req_o,
    output logic                       frame_error_o
);
    typedef enum logic [1:0] {StWaitSync, StWrite, StCommit} state_t;

    localparam logic [3:0] LockTarget = 4'(LOCK_FRAMES);

    state_t state, state_next;

    logic [23:0]              shifter;
    logic [4:0]               bit_cnt;
    logic [2:0]               cur_chan;
    logic                     busy;
    logic [23:0]              hold_data;
    logic [2:0]               hold_chan;
    logic                     hold_full;
    logic [2:0]               expected_chan, expected_next;
    logic [CIRC_BUF_BITS-1:0] write_frame, last_good;
    logic [3:0]               good_cnt, good_inc;
    logic                     resync, frame_error;

    logic last_bit, ready, accept, in_order, pad_bit, write_bit;
    logic load_in, load_hold, hold_load, hold_clear;
    logic drop, frame_abort, commit, lock_abort;

`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
    logic [3:0] user_q;

    // Slot 0 bits 24..27 carry user bits, bit 24 first = user_q[3].
    assign pad_bit = (cur_chan == 3'd0) && (bit_cnt[4:2] == 3'b110) && user_q[~bit_cnt[1:0]];
`else
    assign pad_bit = 1'b0;
`endif

    assign write_bit = (bit_cnt[4:3] == 2'b11) ? pad_bit : shifter[23];

    assign ram_write_en_o   = (state == StWrite) && busy;
    assign ram_write_addr_o = ram_write_en_o ? {write_frame, cur_chan, bit_cnt} : '0;
    assign ram_write_data_o = ram_write_en_o && write_bit;

    assign last_bit = ram_write_en_o && (bit_cnt == 5'd31);
    // The holding register can only drain into the shifter between channels of one frame.
    assign ready    = !hold_full || (last_bit && cur_chan != 3'd7);
    assign accept   = bus.sample_valid_i && ready;
    assign in_order = (bus.sample_chan_i == expected_chan);
    assign good_inc = (good_cnt == 4'hF) ? 4'hF : good_cnt + 4'd1;

    assign bus.sample_ready_o     = ready;
    assign last_good_frame_idx_o  = last_good;
    assign resync_req_o           = resync;
    assign frame_error_o          = frame_error;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= StWaitSync;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        state_next    = state;
        expected_next = expected_chan;
        load_in       = 1'b0;
        load_hold     = 1'b0;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        drop          = 1'b0;
        frame_abort   = 1'b0;
        commit        = 1'b0;
        lock_abort    = 1'b0;
        if (!adat_locked_i) begin
            lock_abort = 1'b1;
            state_next = StWaitSync;
        end else begin
            case (state)
                StWaitSync: begin
                    if (hold_full) begin
                        hold_clear = 1'b1;
                        if (hold_chan == 3'd0) begin
                            load_hold     = 1'b1;
                            expected_next = 3'd1;
                            state_next    = StWrite;
                        end
                    end else if (accept && bus.sample_chan_i == 3'd0) begin
                        load_in       = 1'b1;
                        expected_next = 3'd1;
                        state_next    = StWrite;
                    end
                end
                StWrite, StCommit: begin
                    if (state == StCommit) begin
                        commit     = 1'b1;
                        state_next = StWaitSync;
                    end else if (last_bit && cur_chan == 3'd7) begin
                        state_next = StCommit;
                    end
                    if (last_bit && cur_chan != 3'd7 && hold_full) begin
                        load_hold  = 1'b1;
                        hold_clear = 1'b1;
                    end
                    if (accept) begin
                        if (in_order) begin
                            expected_next = expected_chan + 3'd1;
                            if (state == StWrite &&
                                ((last_bit && cur_chan != 3'd7 && !hold_full) || !busy))
                                load_in = 1'b1;
                            else
                                hold_load = 1'b1;
                        end else begin
                            drop = 1'b1;
                            // expected_chan == 0 means the current frame is complete; only the stray sample is lost.
                            if (expected_chan != 3'd0) begin
                                load_hold  = 1'b0;
                                hold_clear = 1'b1;
                                if (bus.sample_chan_i == 3'd0) begin
                                    load_in       = 1'b1;
                                    expected_next = 3'd1;
                                    state_next    = StWrite;
                                end else begin
                                    frame_abort = 1'b1;
                                    state_next  = StWaitSync;
                                end
                            end
                        end
                    end
                end
                default: state_next = StWaitSync;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later statements override earlier ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shifter       <= '0;
            bit_cnt       <= '0;
            cur_chan      <= '0;
            busy          <= 1'b0;
            hold_data     <= '0;
            hold_chan     <= '0;
            hold_full     <= 1'b0;
            expected_chan <= '0;
            write_frame   <= CIRC_BUF_BITS'(1);
            last_good     <= '0;
            good_cnt      <= '0;
            resync        <= 1'b0;
            frame_error   <= 1'b0;
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
            user_q        <= '0;
`endif
        end else begin
            frame_error   <= drop;
            expected_chan <= expected_next;
            if (ram_write_en_o) begin
                shifter <= {shifter[22:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) busy <= 1'b0;
            end
            if (load_hold) begin
                shifter  <= hold_data;
                cur_chan <= hold_chan;
                bit_cnt  <= '0;
                busy     <= 1'b1;
            end
            if (load_in) begin
                shifter  <= bus.sample_i;
                cur_chan <= bus.sample_chan_i;
                bit_cnt  <= '0;
                busy     <= 1'b1;
            end
            if (hold_clear) hold_full <= 1'b0;
            if (hold_load) begin
                hold_data <= bus.sample_i;
                hold_chan <= bus.sample_chan_i;
                hold_full <= 1'b1;
            end
            if (frame_abort) busy <= 1'b0;
            if (commit) begin
                last_good   <= write_frame;
                write_frame <= write_frame + 1'b1;
                good_cnt    <= good_inc;
                if (good_inc >= LockTarget) resync <= 1'b1;
            end
            if (drop) good_cnt <= '0;
            if (lock_abort) begin
                busy      <= 1'b0;
                hold_full <= 1'b0;
                good_cnt  <= '0;
                resync    <= 1'b0;
            end
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
            if (accept && bus.sample_chan_i == 3'd0) user_q <= bus.user_bits_i;
`endif
        end
    end
endmodule

// File: tb/tb_adat_frame_writer.sv
// Directed bench for adat_frame_writer: RAM writes are predicted into a scoreboard
// queue when samples are accepted and compared as the DUT writes them.
module tb_adat_frame_writer;
    localparam int CB = 3;
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          locked;
    logic [CB+7:0] waddr;
    logic          wdata;
    logic          wen;
    logic [CB-1:0] last_good;
    logic          resync;
    logic          ferr;

    adat_frame_writer_if bus();

    adat_frame_writer #(.CIRC_BUF_BITS(CB), .LOCK_FRAMES(4)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .adat_locked_i         (locked),
        .bus                   (bus),
        .ram_write_addr_o      (waddr),
        .ram_write_data_o      (wdata),
        .ram_write_en_o        (wen),
        .last_good_frame_idx_o (last_good),
        .resync_req_o          (resync),
        .frame_error_o         (ferr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CB+7:0] addr;
        logic          data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;
    bit  sb_on = 1'b1;
    int  wr_count = 0;
    int  err_pulses = 0;
    int  exp_frame = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ferr === 1'b1) err_pulses++;
        if (wen === 1'b1) begin
            wr_count++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(waddr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(waddr), 32'(mon_e.addr));
                    check("wr_data", 32'(wdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic push_slot(input logic [2:0] chan, input logic [23:0] s, input logic [3:0] ub);
        wr_t e;
        for (int k = 0; k < 32; k++) begin
            e.addr = {exp_frame[CB-1:0], chan, k[4:0]};
            if (k < 24)                                e.data = s[23-k];
            else if (USER_EN && chan == 3'd0 && k < 28) e.data = ub[27-k];
            else                                       e.data = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [2:0] chan, input logic [23:0] s, input logic [3:0] ub, input bit push);
        int n = 0;
        @(negedge clk);
        bus.sample_valid_i = 1'b1;
        bus.sample_chan_i  = chan;
        bus.sample_i       = s;
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
        bus.user_bits_i    = ub;
`endif
        while (bus.sample_ready_o !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bounded", 32'(n < 1000), 32'd1);
        @(posedge clk);
        #1;
        bus.sample_valid_i = 1'b0;
        if (push) push_slot(chan, s, ub);
    endtask

    task automatic send_frame(input logic [23:0] base, input logic [3:0] ub, input logic exp_resync,
                              input bit lat, input string tag);
        int n = 0;
        for (int c = 0; c < 8; c++) begin
            send(c[2:0], base + 24'(c), ub, 1'b1);
            if (lat && c == 0) begin
                @(negedge clk);
                check({tag, "_first_wr_en"}, 32'(wen), 32'd1);
                check({tag, "_first_wr_addr"}, 32'(waddr), 32'({exp_frame[CB-1:0], 8'h00}));
                check({tag, "_first_wr_data"}, 32'(wdata), 32'(base[23]));
            end
        end
        while (last_good !== exp_frame[CB-1:0] && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_commit_idx"}, 32'(last_good), 32'(exp_frame[CB-1:0]));
        check({tag, "_resync"}, 32'(resync), 32'(exp_resync));
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        exp_frame = (exp_frame + 1) % (1 << CB);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        rst                = 1'b1;
        locked             = 1'b1;
        bus.sample_valid_i = 1'b0;
        bus.sample_chan_i  = 3'd0;
        bus.sample_i       = 24'd0;
`ifdef ADAT_FRAME_WRITER_USER_BITS_EN
        bus.user_bits_i    = 4'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.sample_ready_o), 32'd1);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_last_good", 32'(last_good), 32'd0);
        check("rst_resync", 32'(resync), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        rst = 1'b0;

        // Frame 1: 0xA5A5A5+chan, user bits 1010 (visible only with the macro).
        wr_count = 0;
        send_frame(24'hA5A5A5, 4'b1010, 1'b0, 1'b1, "f1");
        check("f1_write_count", 32'(wr_count), 32'd256);
        send_frame(24'h123456, 4'b0000, 1'b0, 1'b0, "f2");
        send_frame(24'hFEDCBA, 4'b0110, 1'b0, 1'b0, "f3");
        send_frame(24'h800001, 4'b0000, 1'b1, 1'b0, "f4");

        // Channels 0,1,3: frame dropped, only ch0 reaches the RAM.
        err_pulses = 0;
        send(3'd0, 24'h5A5A5A, 4'd0, 1'b1);
        send(3'd1, 24'h111111, 4'd0, 1'b0);
        send(3'd3, 24'h333333, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        check("err_pulse_cycles", 32'(err_pulses), 32'd1);
        check("err_last_good", 32'(last_good), 32'd4);
        check("err_sb_drained", 32'(exp_q.size()), 32'd0);
        check("err_writes_idle", 32'(wen), 32'd0);
        send_frame(24'h0F0F0F, 4'b0000, 1'b1, 1'b0, "f5_rewrite");

        // Lock loss while channel 5 is being written.
        sb_on    = 1'b0;
        wr_count = 0;
        for (int c = 0; c < 6; c++) send(c[2:0], 24'h3C3C3C + 24'(c), 4'd0, 1'b0);
        n = 0;
        while (wr_count < 168 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ld_reached_ch5", 32'(wr_count >= 168), 32'd1);
        locked = 1'b0;
        @(negedge clk);
        check("ld_resync_low", 32'(resync), 32'd0);
        check("ld_wen_low", 32'(wen), 32'd0);
        snap = wr_count;
        repeat (40) @(negedge clk);
        check("ld_writes_stopped", 32'(wr_count), 32'(snap));
        check("ld_no_commit", 32'(last_good), 32'd5);
        locked = 1'b1;
        sb_on  = 1'b1;

        // 2^CB+1 frames starting at index 6: wraps 7 -> 0 and resync needs 4 fresh commits.
        for (int f = 0; f < (1 << CB) + 1; f++)
            send_frame(24'h010203 * 24'(f + 1), 4'(f), (f >= 3) ? 1'b1 : 1'b0, 1'b0, "wrap");
        check("wrap_final_idx", 32'(last_good), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
